// File: rtl/mpsq_acc_pkg.sv
// Shared widths, types and the rounding helper for the MPSQ product accumulator.
package mpsq_acc_pkg;

  localparam int DEF_PROD_W = 37;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;

  typedef logic [DEF_PROD_W-1:0] prod_t;
  typedef logic [DEF_ACC_W-1:0]  acc_t;
  typedef logic [DEF_CNT_W-1:0]  cnt_t;

  // Half an LSB of the kept result: added before the shift for round-half-up.
  function automatic logic [63:0] round_half(input int shift);
    return 64'd1 << (shift - 1);
  endfunction

endpackage

// File: rtl/mpsq_vld_tracker.sv
// Valid/last shift register that follows operands through the ce-gated multiplier.
module mpsq_vld_tracker #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic in_vld,
  input  logic in_lst,
  output logic tail_v,
  output logic tail_l
);

  logic [LAT-1:0] vld_sr;
  logic [LAT-1:0] lst_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_sr <= '0;
      lst_sr <= '0;
    end else if (ce) begin
      vld_sr[0] <= in_vld;
      lst_sr[0] <= in_lst;
      for (int i = 1; i < LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        lst_sr[i] <= lst_sr[i-1];
      end
    end
  end

  assign tail_v = vld_sr[LAT-1];
  assign tail_l = lst_sr[LAT-1];

endmodule

// File: rtl/mpsq_mul_accum.sv
// Rounds and accumulates multiplier products per group; one result per in_last.
// Optional build macro MPSQ_ACC_SAT_EN: saturating accumulator plus out_ovf flag.
module mpsq_mul_accum
  import mpsq_acc_pkg::*;
#(
  parameter int PROD_W  = DEF_PROD_W,
  parameter int MUL_LAT = 3,
  parameter int SHIFT   = 16,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mul_ce,
  input  logic [PROD_W-1:0] mul_dout,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MPSQ_ACC_SAT_EN
  output logic              out_ovf,
`endif
  output logic [ACC_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count
);

  localparam int TERM_W = PROD_W + 1 - SHIFT;
  localparam logic [PROD_W:0] RND = (PROD_W+1)'(round_half(SHIFT));

  // valid/ready: a beat transfers on an edge where valid & ready are both high;
  // a stalled output freezes the whole pipeline, multiplier included.
  logic stall;
  logic accept;
  logic tail_v;
  logic tail_l;

  assign stall    = out_valid & ~out_ready;
  assign mul_ce   = ~stall;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  mpsq_vld_tracker #(.LAT(MUL_LAT)) u_trk (
    .clk    (clk),
    .reset  (reset),
    .ce     (mul_ce),
    .in_vld (accept),
    .in_lst (in_last),
    .tail_v (tail_v),
    .tail_l (tail_l)
  );

  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W:0]   rnd_sum;
  logic [TERM_W-1:0] term;
  logic [ACC_W:0]    acc_n;
  logic [ACC_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_n;

  // The extra top bit keeps the rounding carry of an all-ones product.
  assign rnd_sum = {1'b0, mul_dout} + RND;
  assign term    = rnd_sum[PROD_W:SHIFT];
  assign acc_n   = {1'b0, acc} + (ACC_W+1)'(term);
  assign cnt_n   = (cnt == '1) ? cnt : cnt + CNT_W'(1);

`ifdef MPSQ_ACC_SAT_EN
  logic sat_hit;
  logic grp_ovf;
  assign sat_hit = acc_n[ACC_W];
  assign acc_q   = sat_hit ? '1 : acc_n[ACC_W-1:0];
`else
  assign acc_q   = acc_n[ACC_W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef MPSQ_ACC_SAT_EN
      out_ovf   <= 1'b0;
      grp_ovf   <= 1'b0;
`endif
    end else if (!stall) begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (tail_v) begin
        if (tail_l) begin
          out_data  <= acc_q;
          out_count <= cnt_n;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
`ifdef MPSQ_ACC_SAT_EN
          out_ovf   <= grp_ovf | sat_hit;
          grp_ovf   <= 1'b0;
`endif
        end else begin
          acc <= acc_q;
          cnt <= cnt_n;
`ifdef MPSQ_ACC_SAT_EN
          grp_ovf <= grp_ovf | sat_hit;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mpsq_mul_accum.sv
// Directed bench for mpsq_mul_accum with a ce-gated 3-stage multiplier model.
module tb_mpsq_mul_accum;
  import mpsq_acc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mul_ce;
  prod_t       mul_dout;
  logic        out_valid;
  logic        out_ready = 1'b1;
  acc_t        out_data;
  cnt_t        out_count;
`ifdef MPSQ_ACC_SAT_EN
  logic        out_ovf;
`endif
  logic [17:0] din0 = '0;
  logic [19:0] din1 = '0;
  prod_t       p1, p2, p3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Multiplier model: unreset, advances only when ce is high.
  always @(posedge clk) begin
    if (mul_ce) begin
      p1 <= 37'(din0) * 37'(din1);
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign mul_dout = p3;

  mpsq_mul_accum dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mul_ce    (mul_ce),
    .mul_dout  (mul_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MPSQ_ACC_SAT_EN
    .out_ovf   (out_ovf),
`endif
    .out_data  (out_data),
    .out_count (out_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [17:0] a, input logic [19:0] b, input logic last);
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL wait_out: out_valid still 0 after %0d cycles, required 1", budget);
    end
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    reset = 1'b0;
    step();
    chk("idle_mul_ce", 64'(mul_ce), 64'd1);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Single term: 65536*3 -> 3, visible four cycles after presentation
    send(18'd65536, 20'd3, 1'b1);
    chk("single_lat1", 64'(out_valid), 64'd0);
    step();
    chk("single_lat2", 64'(out_valid), 64'd0);
    step();
    chk("single_lat3", 64'(out_valid), 64'd0);
    step();
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_data", 64'(out_data), 64'd3);
    chk("single_count", 64'(out_count), 64'd1);
    step();
    chk("single_one_cycle", 64'(out_valid), 64'd0);

    // Rounding boundaries
    send(18'd1, 20'd32768, 1'b1);
    wait_out(10);
    chk("round_half_up", 64'(out_data), 64'd1);
    step();
    send(18'd1, 20'd32767, 1'b1);
    wait_out(10);
    chk("round_below_half", 64'(out_data), 64'd0);
    step();
    send(18'd3, 20'd32768, 1'b1);
    wait_out(10);
    chk("round_1p5", 64'(out_data), 64'd2);
    step();

    // Group of five with a bubble after term 2
    send(18'd65536, 20'd10, 1'b0);
    send(18'd65536, 20'd10, 1'b0);
    chk("grp_no_out_a", 64'(out_valid), 64'd0);
    step();
    send(18'd65536, 20'd10, 1'b0);
    chk("grp_no_out_b", 64'(out_valid), 64'd0);
    send(18'd65536, 20'd10, 1'b0);
    chk("grp_no_out_c", 64'(out_valid), 64'd0);
    send(18'd65536, 20'd10, 1'b1);
    chk("grp_no_out_d", 64'(out_valid), 64'd0);
    wait_out(10);
    chk("grp_data", 64'(out_data), 64'd50);
    chk("grp_count", 64'(out_count), 64'd5);
    step();
    chk("grp_drained", 64'(out_valid), 64'd0);

    // Backpressure: two single-term groups held behind out_ready=0
    out_ready = 1'b0;
    send(18'd65536, 20'd7, 1'b1);
    send(18'd65536, 20'd9, 1'b1);
    wait_out(10);
    chk("bp_first_data", 64'(out_data), 64'd7);
    chk("bp_mul_ce_low", 64'(mul_ce), 64'd0);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_data", 64'(out_data), 64'd7);
    end
    out_ready = 1'b1;
    step();
    chk("bp_second_valid", 64'(out_valid), 64'd1);
    chk("bp_second_data", 64'(out_data), 64'd9);
    chk("bp_second_count", 64'(out_count), 64'd1);
    step();
    chk("bp_all_drained", 64'(out_valid), 64'd0);
    step();
    chk("bp_no_dup", 64'(out_valid), 64'd0);

    // Overflow: 16 terms of 2^20
    for (int i = 0; i < 16; i++) send(18'd131072, 20'd524288, (i == 15));
    wait_out(10);
    chk("ovf_count", 64'(out_count), 64'd16);
`ifdef MPSQ_ACC_SAT_EN
    chk("ovf_data_sat", 64'(out_data), 64'd16777215);
    chk("ovf_flag_set", 64'(out_ovf), 64'd1);
    step();
    send(18'd65536, 20'd3, 1'b1);
    wait_out(10);
    chk("ovf_next_data", 64'(out_data), 64'd3);
    chk("ovf_flag_clear", 64'(out_ovf), 64'd0);
`else
    chk("ovf_data_wrap", 64'(out_data), 64'd0);
`endif
    step();

    // Reset while a term is in flight
    send(18'd65536, 20'd100, 1'b1);
    step();
    reset = 1'b1;
    #1;
    chk("midrst_valid_a", 64'(out_valid), 64'd0);
    step();
    step();
    chk("midrst_valid_b", 64'(out_valid), 64'd0);
    reset = 1'b0;
    chk("midrst_data", 64'(out_data), 64'd0);
    chk("midrst_count", 64'(out_count), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_quiet", 64'(out_valid), 64'd0);
    end
    send(18'd65536, 20'd5, 1'b1);
    wait_out(10);
    chk("midrst_new_data", 64'(out_data), 64'd5);
    chk("midrst_new_count", 64'(out_count), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_single_result", 64'(out_valid), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
